axis_1to4_pack: RTL and testbench
=================================

AXIS_1TO4_PACK -- requirements
Module: axis_1to4_pack

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of user channels; only 4 is supported.
REQ-002 SHALL have parameter LANES, default 8, meaning the number of byte lanes per output word.
REQ-003 SHALL have port clki, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rsti_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s_axis_tvalid / s_axis_tready / s_axis_tlast: in / out / in, 1 bit each, forming the byte stream from the LLC decode FIFO.
REQ-006 SHALL have port s_axis_tdata, input, 8 bits: byte payload.
REQ-007 SHALL have port s_axis_tid, input, 2 bits: destination channel, sampled on the first beat of each packet.
REQ-008 SHALL have ports m_axis_tvalid[3:0], output, and m_axis_tready[3:0], input: per-channel handshake.
REQ-009 SHALL have ports m_axis_tlast[3:0] and m_axis_tkeep[3:0][7:0], outputs: per-channel last flag and byte enables.
REQ-010 SHALL have port m_axis_tdata[3:0][63:0], output: per-channel packed words.
REQ-011 SHALL have ports tid_err_o (output, 1 bit) and tid_err_cnt_o (output, 16 bits): the error monitor (see REQ-026).

Function
REQ-012 SHALL process one packet at a time, through one shared byte accumulator and one output word register.
REQ-013 SHALL latch the channel ch from s_axis_tid on the first accepted beat of each packet.
- The first beat is the first beat after reset, or the first beat after a beat with tlast.
- tid on all later beats of the packet is ignored for routing.
REQ-014 SHALL use two states: IDLE (waiting for a first beat) and PKT (inside a packet).
- IDLE->PKT on an accepted non-last first beat.
- PKT->IDLE on an accepted tlast beat.
- A single-beat packet stays in IDLE.
REQ-015 SHALL fill byte lanes little-endian: the k-th byte of a word goes to bits [8k+7:8k]. The lane counter runs 0..7 and clears when a word is emitted.
REQ-016 SHALL emit a word into the output register on the same clock edge that accepts either the byte filling lane 7 or a tlast byte.
- The word becomes visible at m_axis_* one cycle after that byte's handshake.
REQ-017 SHALL drive m_axis_tkeep as contiguous ones from bit 0, count = bytes in the word. A 3-byte tail gives 8'h07; a full word gives 8'hFF.
REQ-018 SHALL set m_axis_tlast[ch] only on the word holding the packet's tlast byte.
REQ-019 SHALL assert m_axis_tvalid only on bit ch. The other three bits stay 0, and their tdata/tkeep/tlast are 0.
REQ-020 SHALL hold the output word stable until m_axis_tready[ch] is high.
REQ-021 SHALL drive s_axis_tready = !out_valid || m_axis_tready[out_ch], where out_ch is the channel of the word held in the output register.
- This sustains 1 byte/cycle with no bubble when downstream is ready.
REQ-022 SHALL NOT combinationally depend on m_axis_tready for any m_axis_* output.
REQ-023 SHALL NOT drop or duplicate any byte under any pattern of tvalid/tready stalls.

Reset
REQ-024 SHALL, while rsti_n is low, asynchronously force:
- m_axis_tvalid = 0, tlast = 0, tkeep = 0, tdata = 0
- s_axis_tready = 1
- state = IDLE, lane counter = 0
- tid_err_o = 0, tid_err_cnt_o = 0
REQ-025 SHALL discard any partial packet and any pending output word when reset asserts mid-packet. The first beat after reset release is treated as a new first beat.

Configuration
REQ-026 SHALL, when macro LLC_TID_CHECK_EN is defined, flag tid changes inside a packet.
- On an accepted non-first beat whose s_axis_tid differs from ch, tid_err_o pulses high for one cycle.
- On the same event, tid_err_cnt_o increments and saturates at 16'hFFFF.
- Routing is unaffected.
REQ-027 SHALL, when LLC_TID_CHECK_EN is undefined, keep both ports present and drive them constant 0, with no check logic.

Structure
REQ-028 SHALL take NCH, LANES, the state enum (IDLE, PKT) and the channel-id typedef from shared package llc_pkg.
REQ-029 SHALL place the accumulator, lane counter and tkeep generation in sub-module llc_byte_packer. The top level holds the FSM, channel latch, output register and handshake.

Verification
REQ-030 SHALL cover a full packet: 16 bytes 0x00..0x0F, tid=2, tready=1111.
- Expect ch2 word 0x0706050403020100 with tkeep FF.
- Then 0x0F0E0D0C0B0A0908 with tkeep FF and tlast=1.
- No valid on ch0, ch1 or ch3.
REQ-031 SHALL cover a short tail: 11 bytes on tid=1.
- Expect a second word 0x0000000000 0A0908 with tkeep 8'h07 and tlast=1.
REQ-032 SHALL cover backpressure: m_axis_tready[3]=0 for 20 cycles during a 24-byte tid=3 packet.
- s_axis_tready drops within one cycle of the 2nd word being held.
- All 3 words arrive intact, in order, after ready returns.
REQ-033 SHALL cover back-to-back single-byte packets: 0xAA tid=0, then 0xBB tid=1, on consecutive cycles.
- Expect ch0 tkeep 01 data 0xAA tlast=1, then ch1 tkeep 01 data 0xBB tlast=1.
- No input bubble.
REQ-034 SHALL cover reset mid-packet: rsti_n low after byte 5.
- All outputs go to reset values.
- After release, an 8-byte tid=0 packet emits exactly one word with tkeep FF.
REQ-035 SHALL cover the tid check with LLC_TID_CHECK_EN defined: a tid=0 packet whose beat 4 carries tid=2.
- tid_err_o pulses once and tid_err_cnt_o = 1.
- Data is still delivered on ch0.

Source files
------------

// File: rtl/llc_pkg.sv
// -----------------------------------------------------------------------------
// llc_pkg
// Shared definitions for the LLC byte-stream to 4-channel word packer:
//   LLC_NCH      number of user channels (only 4 is supported)
//   LLC_LANES    byte lanes per packed output word
//   llc_state_e  packet FSM state (IDLE waiting for a first beat, PKT inside)
//   llc_ch_t     channel identifier carried on s_axis_tid
//   sat_inc16    saturating 16-bit increment used by the tid error counter
// -----------------------------------------------------------------------------
package llc_pkg;

    localparam int LLC_NCH   = 4;
    localparam int LLC_LANES = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } llc_state_e;

    typedef logic [1:0] llc_ch_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/llc_byte_packer.sv
// -----------------------------------------------------------------------------
// llc_byte_packer
// Shared byte accumulator: collects accepted bytes little-endian into a word
// (k-th byte of a word in bits [8k+7:8k]) and signals when a word is complete,
// either because the last lane was filled or because the byte closes a packet.
// Ports:
//   clki, rsti_n  clock and asynchronous active-low reset
//   beat_acc      a byte is accepted on this clock edge
//   beat_last     the accepted byte carries tlast
//   beat_data     the accepted byte
//   emit          word/keep are complete and must be captured on this edge
//   word          accumulated bytes with the current byte merged at its lane
//   keep          contiguous byte enables from lane 0 up to the current lane
// -----------------------------------------------------------------------------
module llc_byte_packer
    import llc_pkg::*;
#(
    parameter int LANES = LLC_LANES
) (
    input  logic                 clki,
    input  logic                 rsti_n,
    input  logic                 beat_acc,
    input  logic                 beat_last,
    input  logic [7:0]           beat_data,
    output logic                 emit,
    output logic [LANES*8-1:0]   word,
    output logic [LANES-1:0]     keep
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*8-1:0] acc_r;
    logic [LW-1:0]      lane_r;
    logic               lane_full_s;

    assign lane_full_s = (lane_r == LW'(LANES - 1));
    assign emit        = beat_acc && (lane_full_s || beat_last);

    // Present the word as it will look once the current byte is included,
    // so it can be captured on the same edge that accepts that byte.
    always_comb begin
        word = acc_r;
        word[{lane_r, 3'b000} +: 8] = beat_data;
    end

    // Byte enables: every lane up to and including the current one.
    always_comb begin
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LW'(i) <= lane_r) begin
                keep[i] = 1'b1;
            end else begin
                keep[i] = 1'b0;
            end
        end
    end

    // Accumulator and lane counter; both clear whenever a word leaves.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            acc_r  <= '0;
            lane_r <= '0;
        end else if (emit) begin
            acc_r  <= '0;
            lane_r <= '0;
        end else if (beat_acc) begin
            acc_r  <= word;
            lane_r <= lane_r + LW'(1);
        end
    end

endmodule

// File: rtl/axis_1to4_pack.sv
// -----------------------------------------------------------------------------
// axis_1to4_pack
// Packs a single AXI-Stream byte stream into 64-bit words routed to one of four
// output channels. The channel is taken from s_axis_tid on the first beat of
// each packet; one packet is processed at a time through a single accumulator
// and a single output word register.
// Optional feature macro: LLC_TID_CHECK_EN -- when defined, a tid change inside
// a packet pulses tid_err_o and bumps the saturating tid_err_cnt_o; otherwise
// both ports are tied to zero.
// Ports:
//   clki, rsti_n        clock, asynchronous active-low reset
//   s_axis_*            input byte stream (tvalid/tready/tlast/tdata/tid)
//   m_axis_tvalid[c]    word valid on channel c (only the owning channel)
//   m_axis_tready[c]    downstream ready for channel c
//   m_axis_tlast[c]     word holds the packet's final byte
//   m_axis_tkeep[c]     contiguous byte enables from lane 0
//   m_axis_tdata[c]     packed little-endian word
//   tid_err_o           one-cycle pulse on an in-packet tid change
//   tid_err_cnt_o       saturating count of such changes
// -----------------------------------------------------------------------------
module axis_1to4_pack
    import llc_pkg::*;
#(
    parameter int NCH   = LLC_NCH,
    parameter int LANES = LLC_LANES
) (
    input  logic                           clki,
    input  logic                           rsti_n,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic [7:0]                     s_axis_tdata,
    input  logic [1:0]                     s_axis_tid,
    output logic [NCH-1:0]                 m_axis_tvalid,
    input  logic [NCH-1:0]                 m_axis_tready,
    output logic [NCH-1:0]                 m_axis_tlast,
    output logic [NCH-1:0][LANES-1:0]      m_axis_tkeep,
    output logic [NCH-1:0][LANES*8-1:0]    m_axis_tdata,
    output logic                           tid_err_o,
    output logic [15:0]                    tid_err_cnt_o
);

    llc_state_e         state_r;
    llc_ch_t            ch_r;
    llc_ch_t            cur_ch_s;
    llc_ch_t            out_ch_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic [LANES*8-1:0] out_data_r;
    logic [LANES-1:0]   out_keep_r;
    logic               accept_s;
    logic               first_s;
    logic               emit_s;
    logic [LANES*8-1:0] word_s;
    logic [LANES-1:0]   keep_s;

    // The output slot can take a new word if it is empty or draining now.
    assign s_axis_tready = !out_valid_r || m_axis_tready[out_ch_r];
    assign accept_s      = s_axis_tvalid && s_axis_tready;
    assign first_s       = (state_r == IDLE);
    // On a first beat the latch has not been written yet, so route from tid.
    assign cur_ch_s      = first_s ? s_axis_tid : ch_r;

    llc_byte_packer #(
        .LANES (LANES)
    ) u_packer (
        .clki      (clki),
        .rsti_n    (rsti_n),
        .beat_acc  (accept_s),
        .beat_last (s_axis_tlast),
        .beat_data (s_axis_tdata),
        .emit      (emit_s),
        .word      (word_s),
        .keep      (keep_s)
    );

    // Packet FSM and channel latch; a single-beat packet never leaves IDLE.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state_r <= IDLE;
            ch_r    <= 2'd0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    ch_r    <= s_axis_tid;
                    state_r <= s_axis_tlast ? IDLE : PKT;
                end
                PKT: begin
                    if (s_axis_tlast) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output word register: loads on emit, clears valid once the owner takes it.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= 2'd0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= cur_ch_s;
            out_last_r  <= s_axis_tlast;
            out_data_r  <= word_s;
            out_keep_r  <= keep_s;
        end else if (out_valid_r && m_axis_tready[out_ch_r]) begin
            out_valid_r <= 1'b0;
        end
    end

    // Route the held word to its channel only; every other channel reads zero.
    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (out_valid_r && (out_ch_r == llc_ch_t'(c))) begin
                m_axis_tvalid[c] = 1'b1;
                m_axis_tlast[c]  = out_last_r;
                m_axis_tkeep[c]  = out_keep_r;
                m_axis_tdata[c]  = out_data_r;
            end else begin
                m_axis_tvalid[c] = 1'b0;
                m_axis_tlast[c]  = 1'b0;
                m_axis_tkeep[c]  = '0;
                m_axis_tdata[c]  = '0;
            end
        end
    end

`ifdef LLC_TID_CHECK_EN
    logic        tid_err_r;
    logic [15:0] tid_err_cnt_r;

    // Flag a tid that disagrees with the latched channel on a non-first beat.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            tid_err_r     <= 1'b0;
            tid_err_cnt_r <= 16'h0000;
        end else if (accept_s && !first_s && (s_axis_tid != ch_r)) begin
            tid_err_r     <= 1'b1;
            tid_err_cnt_r <= sat_inc16(tid_err_cnt_r);
        end else begin
            tid_err_r     <= 1'b0;
        end
    end

    assign tid_err_o     = tid_err_r;
    assign tid_err_cnt_o = tid_err_cnt_r;
`else
    assign tid_err_o     = 1'b0;
    assign tid_err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_axis_1to4_pack.sv
// -----------------------------------------------------------------------------
// tb_axis_1to4_pack
// Self-checking bench for axis_1to4_pack. Packets are described as byte lists;
// the expected words are cut from those lists in 8-byte chunks and compared in
// order at every output handshake. Directed scenarios cover the full packet,
// short tail, backpressure, single-byte packets, mid-packet reset and the tid
// check, followed by randomized valid/ready traffic.
// -----------------------------------------------------------------------------
module tb_axis_1to4_pack;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] tid;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic [7:0]       s_data;
    logic [1:0]       s_tid;
    logic [3:0]       m_valid;
    logic [3:0]       m_ready;
    logic [3:0]       m_last;
    logic [3:0][7:0]  m_keep;
    logic [3:0][63:0] m_data;
    logic             tid_err;
    logic [15:0]      tid_err_cnt;

    beat_t beat_q[$];
    word_t exp_q[$];
    int    hs_cyc[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    exp_err = 0;
    int    err_pulses = 0;
    int    words_seen = 0;
    logic  sr_last = 1'b0;

    always #5 clk = ~clk;

    axis_1to4_pack dut (
        .clki          (clk),
        .rsti_n        (rst_n),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .s_axis_tdata  (s_data),
        .s_axis_tid    (s_tid),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .m_axis_tkeep  (m_keep),
        .m_axis_tdata  (m_data),
        .tid_err_o     (tid_err),
        .tid_err_cnt_o (tid_err_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue a packet's beats and the words it must produce.
    task automatic add_packet(input int len, input logic [1:0] tid, input int bad_idx,
                              input bit rnd_data, input logic [7:0] base);
        logic [63:0] w;
        logic [7:0]  kp;
        int          k;
        beat_t       b;
        w = 64'd0;
        k = 0;
        for (int i = 0; i < len; i++) begin
            b.data = rnd_data ? 8'($urandom) : 8'(base + 8'(i));
            b.tid  = (i == bad_idx) ? (tid ^ 2'd2) : tid;
            b.last = (i == len - 1);
            beat_q.push_back(b);
            if (i > 0 && b.tid != tid) exp_err++;
            w[8*k +: 8] = b.data;
            k++;
            if (k == 8 || b.last) begin
                kp = 8'hFF >> (8 - k);
                exp_q.push_back(word_t'{ch: tid, data: w, keep: kp, last: b.last});
                w = 64'd0;
                k = 0;
            end
        end
    endtask

    task automatic sample();
        int   nv;
        logic exp_sr;
        word_t e;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            if (m_valid[c]) nv++;
        end
        check_val("valid_onehot", 64'(nv <= 1), 64'd1);
        for (int c = 0; c < 4; c++) begin
            if (m_valid[c]) begin
                if (m_ready[c]) begin
                    if (exp_q.size() == 0) begin
                        check_val("spurious_word", m_data[c], 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("word_ch", 64'(c), 64'(e.ch));
                        check_val("word_data", m_data[c], e.data);
                        check_val("word_keep", 64'(m_keep[c]), 64'(e.keep));
                        check_val("word_last", 64'(m_last[c]), 64'(e.last));
                        hs_cyc.push_back(cyc);
                        words_seen++;
                    end
                end
            end else begin
                check_val("idle_data", m_data[c], 64'd0);
                check_val("idle_keep_last", {55'd0, m_keep[c], m_last[c]}, 64'd0);
            end
        end
        exp_sr = (m_valid == 4'd0) || ((m_valid & m_ready) != 4'd0);
        check_val("s_ready", 64'(s_ready), 64'(exp_sr));
        sr_last = s_ready;
        if (tid_err) err_pulses++;
    endtask

    // One clock: drive at posedge+1, sample on the falling edge.
    task automatic step(input int vp, input bit rrand, input logic [3:0] rfix);
        beat_t b;
        s_valid = (beat_q.size() > 0) && ($urandom_range(99) < vp);
        b = (beat_q.size() > 0) ? beat_q[0] : beat_t'(0);
        s_data  = b.data;
        s_tid   = b.tid;
        s_last  = b.last;
        m_ready = rrand ? 4'($urandom) : rfix;
        @(negedge clk);
        cyc++;
        sample();
        if (s_valid && s_ready) void'(beat_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int vp, input bit rrand);
        int n;
        int exp_eff;
        n = 0;
        while ((beat_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
            step(vp, rrand, 4'hF);
            n++;
        end
        check_val("drain_timeout", 64'(n < 3000), 64'd1);
        repeat (3) step(100, 1'b0, 4'hF);
`ifdef LLC_TID_CHECK_EN
        exp_eff = exp_err;
`else
        exp_eff = 0;
`endif
        check_val("tid_err_pulses", 64'(err_pulses), 64'(exp_eff));
        check_val("tid_err_cnt", 64'(tid_err_cnt), 64'(exp_eff));
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        m_ready = 4'hF;
        rst_n   = 1'b0;
        #1;
        check_val("rst_m_valid", 64'(m_valid), 64'd0);
        check_val("rst_m_last", 64'(m_last), 64'd0);
        check_val("rst_m_keep", 64'(m_keep), 64'd0);
        for (int c = 0; c < 4; c++) check_val("rst_m_data", m_data[c], 64'd0);
        check_val("rst_s_ready", 64'(s_ready), 64'd1);
        check_val("rst_tid_err", {47'd0, tid_err, tid_err_cnt}, 64'd0);
        beat_q.delete();
        exp_q.delete();
        exp_err    = 0;
        err_pulses = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int w0;
        int len;
        int bad;
        logic [3:0] rf;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0; s_tid = 2'd0; m_ready = 4'hF;
        apply_reset();

        // Full 16-byte packet on ch2, downstream always ready.
        hs_cyc.delete();
        base = cyc;
        add_packet(16, 2'd2, -1, 1'b0, 8'h00);
        repeat (20) step(100, 1'b0, 4'hF);
        check_val("full_words", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2) begin
            check_val("full_lat0", 64'(hs_cyc[0] - base), 64'd9);
            check_val("full_lat1", 64'(hs_cyc[1] - base), 64'd17);
        end
        drain(100, 1'b0);

        // 11-byte packet on ch1: second word is a 3-byte tail.
        add_packet(11, 2'd1, -1, 1'b0, 8'h00);
        drain(100, 1'b0);

        // 24-byte packet on ch3 with ch3 ready held low for 20 cycles.
        w0 = words_seen;
        add_packet(24, 2'd3, -1, 1'b0, 8'h40);
        for (int i = 1; i <= 60; i++) begin
            rf = (i >= 10 && i < 30) ? 4'h7 : 4'hF;
            step(100, 1'b0, rf);
            if (i == 16) check_val("bp_ready_before", 64'(sr_last), 64'd1);
            if (i == 17) check_val("bp_ready_drop", 64'(sr_last), 64'd0);
        end
        drain(100, 1'b0);
        check_val("bp_words", 64'(words_seen - w0), 64'd3);

        // Back-to-back single-byte packets.
        hs_cyc.delete();
        base = cyc;
        add_packet(1, 2'd0, -1, 1'b0, 8'hAA);
        add_packet(1, 2'd1, -1, 1'b0, 8'hBB);
        step(100, 1'b0, 4'hF);
        step(100, 1'b0, 4'hF);
        check_val("single_no_bubble", 64'(beat_q.size()), 64'd0);
        step(100, 1'b0, 4'hF);
        step(100, 1'b0, 4'hF);
        check_val("single_words", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2) begin
            check_val("single_lat0", 64'(hs_cyc[0] - base), 64'd2);
            check_val("single_lat1", 64'(hs_cyc[1] - base), 64'd3);
        end
        drain(100, 1'b0);

        // Reset after byte 5 of a packet, then a clean 8-byte packet.
        add_packet(8, 2'd1, -1, 1'b1, 8'h00);
        repeat (5) step(100, 1'b0, 4'hF);
        apply_reset();
        w0 = words_seen;
        add_packet(8, 2'd0, -1, 1'b1, 8'h00);
        drain(100, 1'b0);
        check_val("post_reset_words", 64'(words_seen - w0), 64'd1);

        // tid change on beat 4 of a ch0 packet.
        add_packet(10, 2'd0, 3, 1'b1, 8'h00);
        drain(100, 1'b0);

        // Randomized traffic with random stalls on both sides.
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(20, 1);
            bad = (len > 1 && $urandom_range(2) == 0) ? $urandom_range(len - 1, 1) : -1;
            add_packet(len, 2'($urandom), bad, 1'b1, 8'h00);
            if (p % 10 == 9) drain(70, 1'b1);
        end
        drain(70, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
